histogram_bank_controller: RTL and testbench
============================================

Name: histogram_bank_controller

Overview:
- Sequences histogram accumulation into the dual-port histogram RAM through port B. The RAM is double-banked, 512 x 20, with the bank select on address bit 8.
- While the displayer reads the front bank on port A, this block clears the back bank, accumulates one frame of pixels into it, and tracks the maximum bin value.
- At frame end it swaps banks and publishes the new maximum to the displayer.
- Sits between the camera pixel stream and the histogram RAM/HistogramDisplayer pair.

Parameters:
- BIN_W, 8, pixel/bin index width (2^BIN_W bins per bank)
- CNT_W, 20, bin count width; matches RAM data width

Ports:
- iClk  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iFrameStart  in  1  one-cycle pulse; begins a new histogram frame
- iFrameEnd  in  1  one-cycle pulse; last pixel of the frame has been offered
- iPixValid  in  1  pixel valid
- iPixel  in  BIN_W  pixel intensity = bin index
- oPixReady  out  1  pixel accepted when iPixValid && oPixReady
- oRamAddr  out  BIN_W+1  port-B address {bank, bin}
- oRamWData  out  CNT_W  port-B write data
- oRamWe  out  1  port-B write enable
- iRamRData  in  CNT_W  port-B read data; registered, 1-cycle latency
- oDispBank  out  1  bank the displayer must read (drives port-A address bit BIN_W)
- oMaxValue  out  CNT_W  largest bin count of the published bank
- oHistReady  out  1  one-cycle pulse when a new bank is published
- oBusy  out  1  high in CLEAR/ACCUM/FLUSH

Behaviour:
- Reset state:
  - State is IDLE.
  - All outputs are 0, oDispBank=0, and the run/commit registers are invalid.
  - Reset mid-operation abandons all work. No bank swap occurs.
- State IDLE:
  - iFrameStart moves to CLEAR.
  - oPixReady=0.
- State CLEAR:
  - Runs 2^BIN_W cycles (256 by default).
  - Writes 0 to {~oDispBank, cnt} for cnt = 0..255, with oRamWe=1.
  - Internal max register resets to 0.
  - On the last write, moves to ACCUM.
- State ACCUM:
  - Run coalescing: holds a run register (run_bin, run_cnt, run_valid).
  - Accepted pixel equal to run_bin while run_valid: run_cnt += 1. No RAM access.
  - Accepted pixel differing, or first pixel: the old run, if valid, moves to the commit stage. The new run starts with run_cnt=1.
  - Commit takes 2 cycles:
    - CM_RD: oRamAddr={~oDispBank, cm_bin}, oRamWe=0.
    - CM_WR: oRamWData = iRamRData + cm_cnt, oRamWe=1, same address.
  - oPixReady = (state==ACCUM) && commit stage idle, so it is low for exactly 2 cycles per commit.
  - Read-after-write to the same bin is always at least 1 cycle apart, so no forwarding is required.
  - Max update: on every CM_WR, max = max(max, written value).
- State FLUSH:
  - Entered from ACCUM on iFrameEnd.
  - A pixel accepted in the same cycle as iFrameEnd is counted first.
  - Commits any in-flight commit, then the pending run via CM_RD/CM_WR.
  - Then moves to DONE. oPixReady=0.
- State DONE (1 cycle):
  - Toggles oDispBank.
  - Sets oMaxValue=max and pulses oHistReady.
  - Returns to IDLE.
- iFrameStart in IDLE or DONE:
  - Goes to CLEAR.
  - In DONE, the swap still completes first.
- iFrameStart in CLEAR, ACCUM or FLUSH:
  - Aborts the frame and discards run/commit.
  - Restarts CLEAR on the same back bank.
  - No swap and no oHistReady.
- iFrameEnd outside ACCUM is ignored.
- Pixels offered outside ACCUM are not accepted, since oPixReady=0.
- Arithmetic: run_cnt and the sum are CNT_W bits. Without the optional feature, overflow wraps modulo 2^CNT_W.

Optional Feature:
- Macro: HIST_SATURATE_EN.
- Defined:
  - run_cnt and commit sums clamp at 2^CNT_W-1.
  - Adds output oSatFlag (1 bit): set on any clamp, cleared on entering CLEAR, held through publish.
- Undefined:
  - Counts wrap modulo 2^CNT_W.
  - oSatFlag port absent.

Decomposition:
- Shared package/include histo_defs.vh holds:
  - BIN_W and CNT_W defaults
  - state encodings IDLE/CLEAR/ACCUM/FLUSH/DONE and commit phases CM_IDLE/CM_RD/CM_WR
  - the NUM_BINS constant
- One natural sub-module: histo_run_coalescer. It holds the run register, the compare, and the handoff to the commit stage.
- The FSM, commit sequencing and max tracking stay in the top level.

Test Plan:
- Reset, then iFrameStart -> 256 consecutive cycles with oRamWe=1 writing 0 to addresses 256..511, oBusy=1, oPixReady=0 throughout.
- Pixels 5,5,5,9 then iFrameEnd -> bin 5 = 3 and bin 9 = 1 in bank 1; oDispBank 0->1; oMaxValue=3; exactly one oHistReady pulse.
- 1000 identical pixels of value 200 -> oPixReady never drops until FLUSH; exactly one RAM write to bin 200, value 1000.
- Alternating pixels 1,2,1,2 (8 pixels) -> each change stalls oPixReady for 2 cycles; final bin1=4, bin2=4; no lost counts.
- iFrameStart mid-ACCUM after 50 pixels -> CLEAR restarts on the same back bank; oDispBank unchanged; no oHistReady.
- With HIST_SATURATE_EN, preload bin 7 = 20'hFFFFE and skip CLEAR by forcing state, then 3 pixels of 7 -> bin 7 = 20'hFFFFF and oSatFlag=1. Without the macro -> bin 7 = 20'h00001.

Source files
------------

// File: rtl/histogram_bank_controller_pkg.sv
// histogram_bank_controller_pkg
// Purpose: shared definitions for the histogram bank controller and its run
//          coalescer. It holds the default widths, the top-level state
//          encoding and the commit-stage phase encoding.
// Build option: HIST_SATURATE_EN (used by the importing modules, not here).
package histogram_bank_controller_pkg;

  localparam int BIN_W_DEF = 8;                // pixel / bin index width
  localparam int CNT_W_DEF = 20;               // bin count width (RAM data width)
  localparam int NUM_BINS  = 1 << BIN_W_DEF;   // bins per bank

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CM_IDLE = 2'd0,
    CM_RD   = 2'd1,
    CM_WR   = 2'd2
  } cm_phase_t;

endpackage

// File: rtl/histogram_bank_controller_run_coalescer.sv
// histogram_bank_controller_run_coalescer
// Purpose: collapses runs of identical accepted pixels into one (bin, count)
//          pair. The pending run is handed to the commit stage when a
//          different pixel arrives or when the controller asks for a flush.
// Ports:
//   i_clk, i_rst_n  clock / asynchronous active-low reset
//   i_clear         drop the run (frame abort / restart)
//   i_accept        a pixel is accepted this cycle
//   i_pixel         accepted pixel value (bin index)
//   i_flush         push out the pending run (only while nothing is accepted)
//   o_hand_valid    pending run is handed off this cycle
//   o_hand_bin/cnt  the run being handed off
//   o_run_valid     a run is pending
//   o_sat_hit       run counter clamped this cycle (HIST_SATURATE_EN only)
// Build option: HIST_SATURATE_EN makes the run counter clamp at all-ones.
module histogram_bank_controller_run_coalescer
  import histogram_bank_controller_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic [BIN_W-1:0] i_pixel,
  input  logic             i_flush,
  output logic             o_hand_valid,
  output logic [BIN_W-1:0] o_hand_bin,
  output logic [CNT_W-1:0] o_hand_cnt,
  output logic             o_run_valid
`ifdef HIST_SATURATE_EN
  ,
  output logic             o_sat_hit
`endif
);

  logic [BIN_W-1:0] r_run_bin;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_run_valid;
  logic             w_same;
  logic [CNT_W-1:0] w_inc;

  assign w_same = r_run_valid && (i_pixel == r_run_bin);

`ifdef HIST_SATURATE_EN
  logic [CNT_W:0] w_inc_full;
  assign w_inc_full = {1'b0, r_run_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_inc      = w_inc_full[CNT_W] ? {CNT_W{1'b1}} : w_inc_full[CNT_W-1:0];
  assign o_sat_hit  = !i_clear && i_accept && w_same && w_inc_full[CNT_W];
`else
  assign w_inc = r_run_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
`endif

  // The old run leaves on a differing pixel, or on a flush request.
  assign o_hand_valid = !i_clear && r_run_valid && ((i_accept && !w_same) || i_flush);
  assign o_hand_bin   = r_run_bin;
  assign o_hand_cnt   = r_run_cnt;
  assign o_run_valid  = r_run_valid;

  // Run register: extend, restart, flush or drop the current run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run_bin   <= {BIN_W{1'b0}};
      r_run_cnt   <= {CNT_W{1'b0}};
      r_run_valid <= 1'b0;
    end else if (i_clear) begin
      r_run_cnt   <= {CNT_W{1'b0}};
      r_run_valid <= 1'b0;
    end else if (i_accept) begin
      if (w_same) begin
        r_run_cnt <= w_inc;
      end else begin
        r_run_bin   <= i_pixel;
        r_run_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
        r_run_valid <= 1'b1;
      end
    end else if (i_flush) begin
      r_run_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/histogram_bank_controller.sv
// histogram_bank_controller
// Purpose: drives port B of the double-banked histogram RAM. It clears the
//          back bank, accumulates one frame of pixels into it (runs of equal
//          pixels are coalesced and committed by read-modify-write), tracks
//          the largest bin, then swaps banks and publishes the maximum.
// Ports:
//   iClk, iRST_N      clock / asynchronous active-low reset
//   iFrameStart       pulse: start (or restart) a histogram frame
//   iFrameEnd         pulse: last pixel of the frame has been offered
//   iPixValid/iPixel  pixel stream, accepted when iPixValid && oPixReady
//   oPixReady         pixel can be accepted
//   oRamAddr          port-B address {bank, bin}
//   oRamWData/oRamWe  port-B write data / enable
//   iRamRData         port-B read data, one cycle after the address
//   oDispBank         bank the displayer reads
//   oMaxValue         largest bin count of the published bank
//   oHistReady        pulse: new bank published (oDispBank/oMaxValue valid)
//   oBusy             high in CLEAR/ACCUM/FLUSH
//   oSatFlag          a count clamped this frame (HIST_SATURATE_EN only)
// Build option: HIST_SATURATE_EN selects clamping instead of wrapping counts.
module histogram_bank_controller
  import histogram_bank_controller_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             iClk,
  input  logic             iRST_N,
  input  logic             iFrameStart,
  input  logic             iFrameEnd,
  input  logic             iPixValid,
  input  logic [BIN_W-1:0] iPixel,
  output logic             oPixReady,
  output logic [BIN_W:0]   oRamAddr,
  output logic [CNT_W-1:0] oRamWData,
  output logic             oRamWe,
  input  logic [CNT_W-1:0] iRamRData,
  output logic             oDispBank,
  output logic [CNT_W-1:0] oMaxValue,
  output logic             oHistReady,
  output logic             oBusy
`ifdef HIST_SATURATE_EN
  ,
  output logic             oSatFlag
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  cm_phase_t        r_cm_phase;
  logic [BIN_W-1:0] r_clr_cnt;
  logic [BIN_W-1:0] r_cm_bin;
  logic [CNT_W-1:0] r_cm_cnt;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_max_out;
  logic             r_disp_bank;
  logic             r_hist_ready;
  logic             w_enter_clear;
  logic             w_cm_idle;
  logic             w_accept;
  logic             w_flush;
  logic             w_hand_valid;
  logic [BIN_W-1:0] w_hand_bin;
  logic [CNT_W-1:0] w_hand_cnt;
  logic             w_run_valid;
  logic [CNT_W-1:0] w_sum;

`ifdef HIST_SATURATE_EN
  logic [CNT_W:0]   w_sum_full;
  logic             w_sum_sat;
  logic             w_run_sat;
  logic             r_sat_flag;

  assign w_sum_full = {1'b0, iRamRData} + {1'b0, r_cm_cnt};
  assign w_sum_sat  = w_sum_full[CNT_W];
  assign w_sum      = w_sum_sat ? {CNT_W{1'b1}} : w_sum_full[CNT_W-1:0];
  assign oSatFlag   = r_sat_flag;
`else
  assign w_sum = iRamRData + r_cm_cnt;
`endif

  assign w_cm_idle = (r_cm_phase == CM_IDLE);
  assign oPixReady = (r_state == ACCUM) && w_cm_idle;
  assign w_accept  = iPixValid && oPixReady;
  // The pending run is pushed out only once the commit stage has drained.
  assign w_flush   = (r_state == FLUSH) && w_cm_idle;

  histogram_bank_controller_run_coalescer #(
    .BIN_W (BIN_W),
    .CNT_W (CNT_W)
  ) u_coalescer (
    .i_clk        (iClk),
    .i_rst_n      (iRST_N),
    .i_clear      (w_enter_clear),
    .i_accept     (w_accept),
    .i_pixel      (iPixel),
    .i_flush      (w_flush),
    .o_hand_valid (w_hand_valid),
    .o_hand_bin   (w_hand_bin),
    .o_hand_cnt   (w_hand_cnt),
    .o_run_valid  (w_run_valid)
`ifdef HIST_SATURATE_EN
    ,
    .o_sat_hit    (w_run_sat)
`endif
  );

  // Next-state logic; any iFrameStart outside IDLE/DONE restarts CLEAR.
  always_comb begin
    w_state_nxt   = r_state;
    w_enter_clear = 1'b0;
    case (r_state)
      IDLE: begin
        if (iFrameStart) begin
          w_state_nxt   = CLEAR;
          w_enter_clear = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CLEAR: begin
        if (iFrameStart) begin
          w_state_nxt   = CLEAR;
          w_enter_clear = 1'b1;
        end else if (r_clr_cnt == {BIN_W{1'b1}}) begin
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = CLEAR;
        end
      end
      ACCUM: begin
        if (iFrameStart) begin
          w_state_nxt   = CLEAR;
          w_enter_clear = 1'b1;
        end else if (iFrameEnd) begin
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      FLUSH: begin
        if (iFrameStart) begin
          w_state_nxt   = CLEAR;
          w_enter_clear = 1'b1;
        end else if (w_cm_idle && !w_run_valid) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      DONE: begin
        // The swap below happens regardless; a start just chains into CLEAR.
        if (iFrameStart) begin
          w_state_nxt   = CLEAR;
          w_enter_clear = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge iClk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear address counter.
  always_ff @(posedge iClk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_clr_cnt <= {BIN_W{1'b0}};
    end else if (w_enter_clear) begin
      r_clr_cnt <= {BIN_W{1'b0}};
    end else if (r_state == CLEAR) begin
      r_clr_cnt <= r_clr_cnt + {{(BIN_W-1){1'b0}}, 1'b1};
    end
  end

  // Commit stage: read the bin, then write back read data plus run count.
  always_ff @(posedge iClk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cm_phase <= CM_IDLE;
      r_cm_bin   <= {BIN_W{1'b0}};
      r_cm_cnt   <= {CNT_W{1'b0}};
    end else if (w_enter_clear) begin
      r_cm_phase <= CM_IDLE;
    end else begin
      case (r_cm_phase)
        CM_IDLE: begin
          if (w_hand_valid) begin
            r_cm_phase <= CM_RD;
            r_cm_bin   <= w_hand_bin;
            r_cm_cnt   <= w_hand_cnt;
          end
        end
        CM_RD:   r_cm_phase <= CM_WR;
        CM_WR:   r_cm_phase <= CM_IDLE;
        default: r_cm_phase <= CM_IDLE;
      endcase
    end
  end

  // Running maximum of every value written back this frame.
  always_ff @(posedge iClk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_max <= {CNT_W{1'b0}};
    end else if (w_enter_clear) begin
      r_max <= {CNT_W{1'b0}};
    end else if ((r_cm_phase == CM_WR) && (w_sum > r_max)) begin
      r_max <= w_sum;
    end
  end

  // Publish: swap banks and expose the maximum together with the pulse.
  always_ff @(posedge iClk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_disp_bank  <= 1'b0;
      r_max_out    <= {CNT_W{1'b0}};
      r_hist_ready <= 1'b0;
    end else begin
      r_hist_ready <= (r_state == DONE);
      if (r_state == DONE) begin
        r_disp_bank <= ~r_disp_bank;
        r_max_out   <= r_max;
      end
    end
  end

`ifdef HIST_SATURATE_EN
  // Sticky clamp indicator for the current frame.
  always_ff @(posedge iClk or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sat_flag <= 1'b0;
    end else if (w_enter_clear) begin
      r_sat_flag <= 1'b0;
    end else if (w_run_sat || ((r_cm_phase == CM_WR) && w_sum_sat)) begin
      r_sat_flag <= 1'b1;
    end
  end
`endif

  // Port-B drive, decoded from registered state; quiet (all zero) when idle.
  always_comb begin
    oRamAddr  = {(BIN_W+1){1'b0}};
    oRamWData = {CNT_W{1'b0}};
    oRamWe    = 1'b0;
    if (r_state == CLEAR) begin
      oRamAddr = {~r_disp_bank, r_clr_cnt};
      oRamWe   = 1'b1;
    end else if (r_cm_phase == CM_RD) begin
      oRamAddr = {~r_disp_bank, r_cm_bin};
    end else if (r_cm_phase == CM_WR) begin
      oRamAddr  = {~r_disp_bank, r_cm_bin};
      oRamWData = w_sum;
      oRamWe    = 1'b1;
    end else begin
      oRamWe = 1'b0;
    end
  end

  assign oBusy      = (r_state == CLEAR) || (r_state == ACCUM) || (r_state == FLUSH);
  assign oDispBank  = r_disp_bank;
  assign oMaxValue  = r_max_out;
  assign oHistReady = r_hist_ready;

endmodule

// File: tb/tb_histogram_bank_controller.sv
// tb_histogram_bank_controller
// Self-checking bench: models port B of the histogram RAM, drives directed and
// randomized pixel frames, and compares bank contents, max value, bank swap,
// handshake stalls and write counts against a per-frame bin-count model.
// Build option: HIST_SATURATE_EN (bench follows the DUT build).
module tb_histogram_bank_controller;

  localparam int NB = 256;

  logic        iClk = 1'b0;
  logic        iRST_N = 1'b0;
  logic        iFrameStart = 1'b0;
  logic        iFrameEnd = 1'b0;
  logic        iPixValid = 1'b0;
  logic [7:0]  iPixel = 8'd0;
  logic        oPixReady;
  logic [8:0]  oRamAddr;
  logic [19:0] oRamWData;
  logic        oRamWe;
  logic [19:0] iRamRData = 20'd0;
  logic        oDispBank;
  logic [19:0] oMaxValue;
  logic        oHistReady;
  logic        oBusy;
`ifdef HIST_SATURATE_EN
  logic        oSatFlag;
`endif

  int checks = 0;
  int errors = 0;

  logic [19:0] mem [0:511];
  logic        pre_en = 1'b0;
  logic [8:0]  pre_addr = 9'd0;
  logic [19:0] pre_data = 20'd0;

  // Reference model of the frame being accumulated.
  int   exp_cnt [NB];
  int   pre_val [NB];
  logic exp_disp = 1'b0;
  int   exp_stall, pend_stall, have_last, last_p;
  int   hr_cnt = 0, wr_cnt = 0, stall_cnt = 0;
  int   hr0, wr0, st0;

  histogram_bank_controller dut (
    .iClk        (iClk),
    .iRST_N      (iRST_N),
    .iFrameStart (iFrameStart),
    .iFrameEnd   (iFrameEnd),
    .iPixValid   (iPixValid),
    .iPixel      (iPixel),
    .oPixReady   (oPixReady),
    .oRamAddr    (oRamAddr),
    .oRamWData   (oRamWData),
    .oRamWe      (oRamWe),
    .iRamRData   (iRamRData),
    .oDispBank   (oDispBank),
    .oMaxValue   (oMaxValue),
    .oHistReady  (oHistReady),
    .oBusy       (oBusy)
`ifdef HIST_SATURATE_EN
    ,
    .oSatFlag    (oSatFlag)
`endif
  );

  always #5 iClk = ~iClk;

  // Port-B RAM: synchronous write, registered read; bench preload port.
  always @(posedge iClk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (oRamWe) mem[oRamAddr] <= oRamWData;
    iRamRData <= mem[oRamAddr];
  end

  // Event counters sampled mid-cycle.
  always @(negedge iClk) begin
    if (oHistReady) hr_cnt++;
    if (oRamWe) wr_cnt++;
    if (iPixValid && !oPixReady) stall_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model_val(input int b);
    longint s;
    s = longint'(pre_val[b]) + longint'(exp_cnt[b]);
`ifdef HIST_SATURATE_EN
    if (s > 64'hFFFFF) s = 64'hFFFFF;
`else
    s = s % 64'h100000;
`endif
    return s[19:0];
  endfunction

  function automatic logic [19:0] model_max();
    logic [19:0] m;
    m = 20'd0;
    for (int b = 0; b < NB; b++) if (model_val(b) > m) m = model_val(b);
    return m;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      exp_cnt[b] = 0;
      pre_val[b] = 0;
    end
    pend_stall = 0; exp_stall = 0; have_last = 0; last_p = 0;
  endtask

  // Expect 256 zero-writes to the given bank, then ACCUM with ready high.
  task automatic check_clear(input logic bank);
    int bad;
    bad = 0;
    for (int i = 0; i < NB; i++) begin
      @(negedge iClk);
      if (!(oRamWe === 1'b1 && oRamAddr === {bank, i[7:0]} && oRamWData === 20'd0 &&
            oBusy === 1'b1 && oPixReady === 1'b0 && oHistReady === 1'b0)) bad++;
    end
    chk("clear_seq", bad, 0);
    @(posedge iClk); #1;
    chk("accum_ready", {oPixReady, oRamWe, oBusy}, 3'b101);
  endtask

  task automatic begin_frame();
    model_reset();
    hr0 = hr_cnt;
    iFrameStart = 1'b1;
    @(posedge iClk); #1;
    iFrameStart = 1'b0;
    check_clear(~exp_disp);
    st0 = stall_cnt;
    wr0 = wr_cnt;
  endtask

  task automatic send_pix(input logic [7:0] p, input logic last);
    int t;
    t = 0;
    if (pend_stall != 0) exp_stall += 2;
    iPixValid = 1'b1;
    iPixel = p;
    @(negedge iClk);
    while (!oPixReady && t < 20) begin
      t++;
      @(negedge iClk);
    end
    chk("pix_accept_bound", (t < 20), 1);
    iFrameEnd = last;
    pend_stall = (have_last != 0 && int'(p) != last_p) ? 1 : 0;
    exp_cnt[p]++;
    have_last = 1;
    last_p = int'(p);
    @(posedge iClk); #1;
    iPixValid = 1'b0;
    iFrameEnd = 1'b0;
  endtask

  task automatic finish_frame(input logic pulse_end);
    int t;
    if (pulse_end) begin
      iFrameEnd = 1'b1;
      @(posedge iClk); #1;
      iFrameEnd = 1'b0;
    end
    t = 0;
    @(negedge iClk);
    while (!oHistReady && t < 5000) begin
      t++;
      @(negedge iClk);
    end
    chk("publish_seen", oHistReady, 1'b1);
    exp_disp = ~exp_disp;
    chk("disp_bank", oDispBank, exp_disp);
    chk("max_value", oMaxValue, model_max());
    begin
      int bad;
      bad = 0;
      for (int b = 0; b < NB; b++) if (mem[{exp_disp, b[7:0]}] !== model_val(b)) bad++;
      chk("bank_bins", bad, 0);
    end
    repeat (3) @(posedge iClk);
    #1;
    chk("hist_pulses", hr_cnt - hr0, 1);
    chk("idle_after", {oBusy, oPixReady}, 2'b00);
  endtask

  initial begin
    logic [7:0] p;
    // Reset state
    iPixValid = 1'b1;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    chk("rst_flags", {oPixReady, oRamWe, oDispBank, oHistReady, oBusy}, 5'd0);
    chk("rst_addr", oRamAddr, 9'd0);
    chk("rst_wdata", oRamWData, 20'd0);
    chk("rst_max", oMaxValue, 20'd0);
    @(posedge iClk); #1;
    iRST_N = 1'b1;
    iPixValid = 1'b0;

    // iFrameEnd in IDLE is ignored
    iFrameEnd = 1'b1;
    @(posedge iClk); #1;
    iFrameEnd = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("end_in_idle", {oBusy, oHistReady, oDispBank}, 3'd0);

    // Frame A: 5,5,5,9 then separate iFrameEnd
    begin_frame();
    send_pix(8'd5, 1'b0); send_pix(8'd5, 1'b0); send_pix(8'd5, 1'b0); send_pix(8'd9, 1'b0);
    finish_frame(1'b1);
    chk("a_bin5", mem[9'd261], 20'd3);
    chk("a_bin9", mem[9'd265], 20'd1);
    chk("a_writes", wr_cnt - wr0, 2);

    // Frame B: 1000 identical pixels, end with last pixel
    begin_frame();
    for (int i = 0; i < 1000; i++) send_pix(8'd200, (i == 999));
    finish_frame(1'b0);
    chk("b_stalls", stall_cnt - st0, 0);
    chk("b_writes", wr_cnt - wr0, 1);
    chk("b_bin200", mem[9'd200], 20'd1000);

    // Frame C: alternating 1,2 x8, end with last pixel
    begin_frame();
    for (int i = 0; i < 8; i++) send_pix((i % 2 == 0) ? 8'd1 : 8'd2, (i == 7));
    finish_frame(1'b0);
    chk("c_stalls", stall_cnt - st0, exp_stall);
    chk("c_writes", wr_cnt - wr0, 8);
    chk("c_bin1", mem[9'd257], 20'd4);
    chk("c_bin2", mem[9'd258], 20'd4);

    // Frame D: abort after 50 random pixels, then a random frame with gaps
    begin_frame();
    for (int i = 0; i < 50; i++) send_pix(8'($urandom_range(0, 15)), 1'b0);
    model_reset();
    iFrameStart = 1'b1;
    @(posedge iClk); #1;
    iFrameStart = 1'b0;
    check_clear(~exp_disp);
    chk("abort_disp_kept", oDispBank, exp_disp);
    p = 8'($urandom_range(0, 255));
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) p = 8'($urandom_range(0, 255));
      send_pix(p, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge iClk); #1;
      end
    end
    finish_frame(1'b1);

    // Frame E: random, back-to-back, few bins so counts grow
    begin_frame();
    for (int i = 0; i < 400; i++) send_pix(8'($urandom_range(40, 47)), (i == 399));
    finish_frame(1'b0);

    // Frame F: preload bin 7 near full scale, then 3 pixels of 7
    begin_frame();
    pre_addr = {~exp_disp, 8'd7};
    pre_data = 20'hFFFFE;
    pre_en = 1'b1;
    @(posedge iClk); #1;
    pre_en = 1'b0;
    pre_val[7] = 32'hFFFFE;
    send_pix(8'd7, 1'b0); send_pix(8'd7, 1'b0); send_pix(8'd7, 1'b0);
    finish_frame(1'b1);
`ifdef HIST_SATURATE_EN
    chk("f_bin7", mem[{exp_disp, 8'd7}], 20'hFFFFF);
    chk("f_satflag", oSatFlag, 1'b1);
`else
    chk("f_bin7", mem[{exp_disp, 8'd7}], 20'h00001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
